// File: rtl/usr_sequencer.sv
// usr_sequencer: command-driven controller for a WIDTH-bit universal shift
// register (USR) that sits beside it. It accepts one command at a time
// (LOAD / SHL / SHR / ROL / ROR) and drives the USR strobes for the exact
// number of cycles. It then returns the final register contents with a
// one-cycle done pulse.
//
// Optional feature: define USR_SEQ_ABORT_EN to add the 'abort' input. This
// input ends a running shift/rotate early. The command then completes with
// err=1 and the partially shifted value.
//
// Timing, from the edge t at which a command is accepted:
//   - Every output is registered and changes together with the FSM state.
//   - A strobe that is high in a state's cycle is sampled by the USR on the
//     next edge.
//   - LOAD:             parallel_load sampled at t+1, done sampled at t+3.
//   - Shift/rotate N:   strobes sampled at t+1..t+N, done at t+N+2.
//   - N=0 or reserved:  done at t+2.
module usr_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
`ifdef USR_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] usr_D,
  output logic [WIDTH-1:0] usr_S,
  output logic             usr_parallel_load,
  output logic             usr_shift_left,
  output logic             usr_shift_right,
  input  logic [WIDTH-1:0] usr_Q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // FSM state and latched command fields
  state_t           state_r;
  state_t           state_s;
  logic [2:0]       op_r;
  logic [2:0]       op_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             fill_r;
  logic             fill_s;
  logic             err_flag_r;
  logic             err_flag_s;
  logic [WIDTH-1:0] d_s;

  // Registered outputs
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             pl_r;
  logic             shl_r;
  logic             shr_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] result_r;

  logic             accept_s;
  logic             abort_s;
  logic             left_s;
  logic [WIDTH-1:0] serial_s;

`ifdef USR_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // A command is taken only while idle and advertising ready.
  assign accept_s = cmd_valid && ready_r && (state_r == ST_IDLE);

  // SHL and ROL drive the left strobe; SHR and ROR drive the right strobe.
  assign left_s = (op_s == OP_SHL) || (op_s == OP_ROL);

  // State register: async reset returns to IDLE at once, even mid-command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus the next values of the latched command fields.
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    cnt_s      = cnt_r;
    fill_s     = fill_r;
    err_flag_s = err_flag_r;
    d_s        = {WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          op_s       = cmd_op;
          fill_s     = cmd_fill;
          err_flag_s = 1'b0;
          case (cmd_op)
            OP_LOAD: begin
              state_s = ST_LOAD;
              cnt_s   = CNT_ZERO;
              d_s     = cmd_data;
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
              cnt_s = cmd_count;
              if (cmd_count != CNT_ZERO) begin
                state_s = ST_SHIFT;
              end else begin
                state_s = ST_SETTLE;
              end
            end
            default: begin
              state_s    = ST_SETTLE;
              cnt_s      = CNT_ZERO;
              err_flag_s = 1'b1;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_SETTLE;
      end
      ST_SHIFT: begin
        // The strobe of this cycle is already on the wire. An abort only
        // suppresses the strobes that would follow it.
        if (abort_s) begin
          state_s    = ST_SETTLE;
          cnt_s      = CNT_ZERO;
          err_flag_s = 1'b1;
        end else if (cnt_r == CNT_ONE) begin
          state_s = ST_SETTLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_SHIFT;
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_SETTLE: begin
        state_s = ST_DONE;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Latched command fields: op, remaining count, fill bit and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r       <= OP_LOAD;
      cnt_r      <= CNT_ZERO;
      fill_r     <= 1'b0;
      err_flag_r <= 1'b0;
    end else begin
      op_r       <= op_s;
      cnt_r      <= cnt_s;
      fill_r     <= fill_s;
      err_flag_r <= err_flag_s;
    end
  end

  // Registered USR strobes and parallel data. They are decoded from the
  // next state, so they line up exactly with the LOAD/SHIFT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pl_r  <= 1'b0;
      shl_r <= 1'b0;
      shr_r <= 1'b0;
      d_r   <= {WIDTH{1'b0}};
    end else begin
      pl_r  <= (state_s == ST_LOAD);
      shl_r <= (state_s == ST_SHIFT) && left_s;
      shr_r <= (state_s == ST_SHIFT) && !left_s;
      d_r   <= d_s;
    end
  end

  // Handshake, status and result registers. The result is captured on
  // entry to DONE, when usr_Q already reflects the final strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      err_r   <= (state_s == ST_DONE) && err_flag_s;
      if (state_s == ST_DONE) begin
        result_r <= usr_Q;
      end else begin
        result_r <= result_r;
      end
    end
  end

  // Serial-in bit for the USR: the fill bit for shifts, or the bit that
  // wraps around for rotates. It is replicated on every bit of usr_S.
  always_comb begin
    serial_s = {WIDTH{1'b0}};
    case (op_r)
      OP_SHL, OP_SHR: serial_s = {WIDTH{fill_r}};
      OP_ROL:         serial_s = {WIDTH{usr_Q[WIDTH-1]}};
      OP_ROR:         serial_s = {WIDTH{usr_Q[0]}};
      default:        serial_s = {WIDTH{fill_r}};
    endcase
  end

  assign cmd_ready         = ready_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign err               = err_r;
  assign result            = result_r;
  assign usr_parallel_load = pl_r;
  assign usr_shift_left    = shl_r;
  assign usr_shift_right   = shr_r;
  assign usr_D             = d_r;
  assign usr_S             = serial_s;

endmodule
